// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IF/DM request ports and backing-memory bus shared by the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port (read only)
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ready_o;

  // Data-memory port (read or write)
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ready_o;

  // Backing-memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  // Arbiter view
  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ready_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  // Pipeline and memory view
  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ready_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for a single-ported variable-latency memory; MEM_ARB_RR_EN selects round-robin on conflicts
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]    conflict_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              if_ready_q,  if_ready_d;
  logic              dm_ready_q,  dm_ready_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              conflict;
  logic              any_req;
  logic              grant_dm;

  assign conflict = bus.if_req_i & bus.dm_req_i;
  assign any_req  = bus.if_req_i | bus.dm_req_i;

`ifdef MEM_ARB_RR_EN
  // rr_dm_q=1: the next conflict goes to DM
  logic rr_dm_q, rr_dm_d;

  assign grant_dm = bus.dm_req_i & (~bus.if_req_i | rr_dm_q);

  // Pointer moves to the other port after each grant made in a conflict cycle
  always_comb begin
    rr_dm_d = rr_dm_q;
    if (state_q == IDLE && conflict) begin
      rr_dm_d = ~grant_dm;
    end
  end

  // Pointer register; DM is favoured out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_dm_q <= 1'b1;
    end else begin
      rr_dm_q <= rr_dm_d;
    end
  end
`else
  assign grant_dm = bus.dm_req_i;
`endif

  // Next state and next register values; request inputs only matter in IDLE
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (any_req) begin
          mem_req_d = 1'b1;
          if (grant_dm) begin
            mem_we_d    = bus.dm_we_i;
            mem_addr_d  = bus.dm_addr_i;
            mem_wdata_d = bus.dm_wdata_i;
            state_d     = BUSY_DM;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            state_d     = BUSY_IF;
          end
        end
      end

      BUSY_IF: begin
        if (bus.mem_ack_i) begin
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata_i;
          if_ready_d = 1'b1;
          state_d    = RESP;
        end
      end

      BUSY_DM: begin
        if (bus.mem_ack_i) begin
          mem_req_d  = 1'b0;
          dm_ready_d = 1'b1;
          state_d    = RESP;
          if (!mem_we_q) begin
            dm_rdata_d = bus.mem_rdata_i;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side, response and counter registers; a reset drops any access in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.if_ready_o  = if_ready_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.dm_ready_o  = dm_ready_q;
  assign conflict_cnt_o  = cnt_q;

  // Only one port can ever be completing
  a_one_ready: assert property (@(posedge clk_i) !(if_ready_q && dm_ready_q));

  // An outstanding memory request keeps its address until acknowledged
  a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (mem_req_q && !bus.mem_ack_i) |=> (mem_req_q && $stable(mem_addr_q)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: saturating conflict count, number of conflicts since reset, last read data per port
  int          exp_cnt;
  int          conflicts;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.if_req_i  = 1'b0;
    bus.dm_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt      = 0;
    conflicts    = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  // Nothing in flight: no memory request, no ready pulse, response data and counter as modelled
  task automatic check_quiet(input string tag);
    check({tag, "_mem_req"}, 64'(bus.mem_req_o), 64'd0);
    check({tag, "_ready"}, 64'({bus.if_ready_o, bus.dm_ready_o}), 64'd0);
    check({tag, "_if_rdata"}, 64'(bus.if_rdata_o), 64'(exp_if_rdata));
    check({tag, "_dm_rdata"}, 64'(bus.dm_rdata_o), 64'(exp_dm_rdata));
    check({tag, "_cnt"}, 64'(cnt), 64'(exp_cnt));
  endtask

  // One granted access: the grant is latched at the next edge, held for d wait cycles, acked,
  // and completed with a ready pulse in the cycle after the ack
  task automatic serve(input bit w, input int d, input logic [31:0] ack_data, input bit stray);
    logic [31:0] exp_addr;
    logic        exp_we;
    exp_addr = w ? bus.dm_addr_i : bus.if_addr_i;
    exp_we   = w ? bus.dm_we_i : 1'b0;
    tick();
    check("grant_mem_req", 64'(bus.mem_req_o), 64'd1);
    check("grant_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
    check("grant_we", 64'(bus.mem_we_o), 64'(exp_we));
    if (exp_we) check("grant_wdata", 64'(bus.mem_wdata_o), 64'(bus.dm_wdata_i));
    check("grant_cnt", 64'(cnt), 64'(exp_cnt));
    check("grant_ready", 64'({bus.if_ready_o, bus.dm_ready_o}), 64'd0);
    for (int i = 0; i < d; i++) begin
      tick();
      check("wait_mem_req", 64'(bus.mem_req_o), 64'd1);
      check("wait_addr", 64'(bus.mem_addr_o), 64'(exp_addr));
      check("wait_ready", 64'({bus.if_ready_o, bus.dm_ready_o}), 64'd0);
    end
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = ack_data;
    tick();
    bus.mem_ack_i = 1'b0;
    if (!exp_we) begin
      if (w) exp_dm_rdata = ack_data;
      else   exp_if_rdata = ack_data;
    end
    check("resp_mem_req", 64'(bus.mem_req_o), 64'd0);
    check("resp_if_ready", 64'(bus.if_ready_o), 64'(!w));
    check("resp_dm_ready", 64'(bus.dm_ready_o), 64'(w));
    check("resp_if_rdata", 64'(bus.if_rdata_o), 64'(exp_if_rdata));
    check("resp_dm_rdata", 64'(bus.dm_rdata_o), 64'(exp_dm_rdata));
    if (w) bus.dm_req_i = 1'b0;
    else   bus.if_req_i = 1'b0;
    if (stray) begin
      bus.mem_ack_i   = 1'b1;
      bus.mem_rdata_i = $urandom;
    end
  endtask

  // A round presents one or two requests together and serves them to completion
  task automatic round(input bit do_if, input bit do_dm, input logic [31:0] ia, input logic [31:0] da,
                       input bit we, input logic [31:0] wd, input int d0, input logic [31:0] r0,
                       input int d1, input logic [31:0] r1, input bit stray);
    bit w;
    bus.if_req_i   = do_if;
    bus.if_addr_i  = ia;
    bus.dm_req_i   = do_dm;
    bus.dm_we_i    = we;
    bus.dm_addr_i  = da;
    bus.dm_wdata_i = wd;
    if (do_if && do_dm) begin
      if (exp_cnt < CNT_MAX) exp_cnt++;
`ifdef MEM_ARB_RR_EN
      w = (conflicts % 2) == 0;
`else
      w = 1'b1;
`endif
      conflicts++;
      serve(w, d0, r0, stray);
      tick();
      bus.mem_ack_i = 1'b0;
      check_quiet("between");
      serve(!w, d1, r1, stray);
    end else begin
      serve(do_dm, d0, r0, stray);
    end
    tick();
    bus.mem_ack_i = 1'b0;
    check_quiet("after");
  endtask

  initial begin
    bit a_if, a_dm;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.mem_rdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    rst = 1'b1;

    apply_reset();
    check_quiet("reset");
    check("reset_we", 64'(bus.mem_we_o), 64'd0);
    check("reset_addr", 64'(bus.mem_addr_o), 64'd0);
    check("reset_wdata", 64'(bus.mem_wdata_o), 64'd0);

    // IF read with two wait cycles
    round(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 2, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    // DM write, zero-wait memory
    round(1'b0, 1'b1, 32'h0, 32'h20, 1'b1, 32'h1234, 0, 32'hCAFEF00D, 0, 32'h0, 1'b0);
    // DM read, then simultaneous IF and DM
    round(1'b0, 1'b1, 32'h0, 32'h24, 1'b0, 32'h0, 1, 32'h55AA55AA, 0, 32'h0, 1'b1);
    round(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 32'h0, 0, 32'h11111111, 1, 32'h22222222, 1'b0);

    // Four conflicts from a fresh reset exercise the grant order
    apply_reset();
    check_quiet("reset2");
    for (int i = 0; i < 4; i++) begin
      round(1'b1, 1'b1, $urandom, $urandom, 1'(i % 2), $urandom, 0, $urandom, 1, $urandom, 1'b0);
    end

    // Counter saturation
    for (int i = 0; i < 6; i++) begin
      round(1'b1, 1'b1, $urandom, $urandom, 1'b0, $urandom, 0, $urandom, 0, $urandom, 1'b1);
    end

    // Reset while DM access is outstanding, then a late ack
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h300;
    tick();
    check("abort_mem_req", 64'(bus.mem_req_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.dm_req_i  = 1'b0;
    exp_cnt      = 0;
    conflicts    = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    check_quiet("abort");
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hBADBAD00;
    tick();
    bus.mem_ack_i = 1'b0;
    check_quiet("late_ack");
    tick();
    check_quiet("late_ack2");

    // Random traffic with idle gaps and stray acks
    for (int n = 0; n < 150; n++) begin
      a_if = 1'($urandom_range(0, 1));
      a_dm = 1'($urandom_range(0, 1));
      if (!a_if && !a_dm) a_dm = 1'b1;
      round(a_if, a_dm, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus.mem_ack_i   = 1'($urandom_range(0, 1));
        bus.mem_rdata_i = $urandom;
        tick();
        bus.mem_ack_i = 1'b0;
        check_quiet("idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
